mux_nd_stream: RTL and testbench
================================

Name: mux_nd_stream

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Generalises the 2-input combinational mux to DEPTH channels and adds an output register stage.
- Two selection modes:
  - explicit select, driven by `sel`;
  - round-robin arbitration.
- Used between pipeline stages and bus sources where multiple producers share one consumer.

Parameters:
- WIDTH, 32, bit width of each data channel.
- DEPTH, 4, number of input channels (DEPTH >= 2).
- SEL_W, $clog2(DEPTH), select/source index width. This is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = explicit select via `sel`; 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode=0.
- din  input  DEPTH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- din_valid  input  DEPTH  per-channel valid.
- din_ready  output  DEPTH  per-channel ready; combinational, at most one bit high.
- dout  output  WIDTH  registered output data.
- dout_valid  output  1  registered output valid.
- dout_ready  input  1  consumer ready.
- dout_src  output  SEL_W  index of the channel that produced the current dout.

Behaviour:
- Reset (async, reset_n=0): dout=0, dout_valid=0, dout_src=0, rr_ptr=0. din_ready=0 while reset_n=0. In-flight data is discarded.
- Output slot enable: load_en = !dout_valid | dout_ready.
- Grant, mode=0:
  - g=sel if sel<DEPTH and din_valid[sel]; otherwise no grant.
  - sel>=DEPTH (non-power-of-2 DEPTH) never grants.
- Grant, mode=1:
  - g = first i with din_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, DEPTH-1, 0, …, rr_ptr-1.
  - No grant if din_valid=0.
- din_ready[g] = load_en & grant_valid. All other din_ready bits are 0.
- Transfer on a clock edge with load_en & grant_valid:
  - dout<=din[g], dout_src<=g, dout_valid<=1.
  - In mode 1 only: rr_ptr <= (g==DEPTH-1) ? 0 : g+1.
- On load_en & !grant_valid: dout_valid<=0. dout and dout_src hold their last values.
- On !load_en (dout_valid=1, dout_ready=0): dout, dout_src and dout_valid hold; all din_ready=0.
- Latency: 1 cycle from input accept to dout_valid.
- Throughput: 1 transfer/cycle when dout_ready=1 continuously. No bubble on simultaneous drain+load.
- Mode switch: takes effect at the next grant evaluation. rr_ptr is retained across mode 0 periods and not updated during them.
- `sel` and `mode` are sampled combinationally each cycle. Changing them while dout_valid=1 does not affect the held output.
- Inputs follow valid/ready protocol: a channel must hold data stable while valid=1 and ready=0. The block does not check this.

Optional Feature:
- Macro: MUX_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt[DEPTH*16-1:0], one 16-bit counter per channel at [i*16 +: 16].
  - The counter for channel i increments on each accepted transfer from i and saturates at 16'hFFFF.
  - Adds input cnt_clr (1 bit): synchronous clear of all counters; clear wins over increment in the same cycle.
  - Async reset clears all counters to 0.
- Undefined: grant_cnt and cnt_clr ports are absent. No counter logic is generated; base behaviour is unchanged.

Test Plan:
- Explicit select: DEPTH=4, mode=0, sel=2, din[2]=32'hDEADBEEF, din_valid=4'b0100, dout_ready=1 → din_ready=4'b0100 in the accept cycle; next cycle dout=32'hDEADBEEF, dout_src=2, dout_valid=1.
- Backpressure: dout_valid=1, dout_ready=0 for 5 cycles with all din_valid=1 → din_ready=0 throughout, dout/dout_src stable. Then dout_ready=1 → a new word is loaded the same cycle, with no bubble.
- Round-robin fairness: mode=1, din_valid=4'b1111 held, dout_ready=1 → dout_src sequence 0,1,2,3,0,1, one per cycle.
- Round-robin skip: mode=1, rr_ptr=2, din_valid=4'b1010 held → dout_src sequence 3,1,3,1.
- Out-of-range select: DEPTH=3, mode=0, sel=3, din_valid=3'b111 → din_ready=0; dout_valid falls to 0 after the current word drains; dout holds its last value.
- Async reset mid-stream: drop reset_n between clock edges while dout_valid=1 → dout_valid=0, dout=0, dout_src=0 immediately. After release, round-robin restarts at channel 0. With MUX_GRANT_CNT_EN defined, all grant_cnt fields read 0.

Source files
------------

// File: rtl/mux_nd_stream.sv
// mux_nd_stream
// ---------------------------------------------------------------------------
// N-input registered multiplexer with valid/ready handshakes on every input
// channel and on the output. The winning channel is chosen either by an
// explicit index (mode=0, `sel`) or by round-robin arbitration (mode=1). The
// output is a single register slot that can drain and reload in one cycle.
//
// Parameters:
//   WIDTH  data width of each channel
//   DEPTH  number of input channels (>= 2)
//   SEL_W  index width, derived from DEPTH (not overridable)
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   mode        0 = explicit select, 1 = round-robin
//   sel         channel index used in mode 0
//   din         flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   din_valid   per-channel valid
//   din_ready   per-channel ready (combinational, one-hot or zero)
//   dout        registered output data
//   dout_valid  registered output valid
//   dout_ready  consumer ready
//   dout_src    channel index that produced the current dout
//
// Optional feature, enabled by defining MUX_GRANT_CNT_EN:
//   cnt_clr     synchronous clear of all grant counters (wins over increment)
//   grant_cnt   saturating 16-bit accepted-transfer counter per channel,
//               channel i at [i*16 +: 16]
// ---------------------------------------------------------------------------
module mux_nd_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DEPTH*WIDTH-1:0] din,
  input  logic [DEPTH-1:0]       din_valid,
  output logic [DEPTH-1:0]       din_ready,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [SEL_W-1:0]       dout_src
`ifdef MUX_GRANT_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [DEPTH*16-1:0]    grant_cnt
`endif
);

  logic [WIDTH-1:0] din_arr [DEPTH];

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [SEL_W-1:0] dout_src_q, dout_src_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign din_arr[i] = din[i*WIDTH +: WIDTH];
  end

  // The slot can take a new word when it is empty or being drained this cycle.
  assign load_en = !dout_valid_q || dout_ready;

  // Grant selection.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (!mode) begin
      // Indices >= DEPTH (non-power-of-2 DEPTH) never grant.
      if (int'(sel) < DEPTH) begin
        if (din_valid[sel]) begin
          grant_valid = 1'b1;
          grant_idx   = sel;
        end
      end
    end else begin
      // Scan rr_ptr, rr_ptr+1, ... wrapping at DEPTH; first requester wins.
      for (int k = 0; k < DEPTH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= DEPTH) idx = idx - DEPTH;
        if (!grant_valid && din_valid[SEL_W'(idx)]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(idx);
        end
      end
    end
  end

  // Ready is forced low while reset is asserted even though load_en is high.
  assign xfer = reset_n && load_en && grant_valid;

  always_comb begin
    din_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      din_ready[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_src_d   = dout_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (load_en) begin
      // An empty grant empties the slot but leaves data/source as they were.
      dout_valid_d = grant_valid;
      if (grant_valid) begin
        dout_d     = din_arr[grant_idx];
        dout_src_d = grant_idx;
        // The pointer only advances on round-robin grants; explicit-select
        // periods leave it where it was.
        if (mode) begin
          rr_ptr_d = (grant_idx == SEL_W'(DEPTH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_src_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_src_q   <= dout_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_src   = dout_src_q;

`ifdef MUX_GRANT_CNT_EN
  logic [15:0] cnt_q [DEPTH];
  logic [15:0] cnt_d [DEPTH];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      for (int i = 0; i < DEPTH; i++) cnt_d[i] = '0;
    end else if (xfer && cnt_q[grant_idx] != 16'hFFFF) begin
      cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
    end
  end

  // NOTE: this register array is reset explicitly; the counts are
  // architecturally visible and must read zero after reset, unlike a data
  // buffer whose contents are qualified by a valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cnt_out
    assign grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mux_nd_stream.sv
// Self-checking bench for mux_nd_stream. Two instances run side by side: a
// 4-channel one and a 3-channel one (for the out-of-range select case). A
// behavioural model derived from the grant/transfer rules predicts ready,
// data, valid and source for each cycle; directed steps cover the main
// scenarios and a randomized phase covers mode/select/backpressure mixes.
module tb_mux_nd_stream;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic         mode4 = 1'b0;
  logic [1:0]   sel4 = '0;
  logic [127:0] din4 = '0;
  logic [3:0]   val4 = '0;
  logic [3:0]   din_ready4;
  logic [31:0]  dout4;
  logic         dout_valid4;
  logic         rdy4 = 1'b0;
  logic [1:0]   dout_src4;

  // 3-channel instance
  logic         mode3 = 1'b0;
  logic [1:0]   sel3 = '0;
  logic [95:0]  din3 = '0;
  logic [2:0]   val3 = '0;
  logic [2:0]   din_ready3;
  logic [31:0]  dout3;
  logic         dout_valid3;
  logic         rdy3 = 1'b0;
  logic [1:0]   dout_src3;

  logic cnt_clr = 1'b0;
`ifdef MUX_GRANT_CNT_EN
  logic [63:0] gc4;
  logic [47:0] gc3;
`endif

  mux_nd_stream #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode4), .sel(sel4), .din(din4),
    .din_valid(val4), .din_ready(din_ready4), .dout(dout4),
    .dout_valid(dout_valid4), .dout_ready(rdy4), .dout_src(dout_src4)
`ifdef MUX_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt(gc4)
`endif
  );

  mux_nd_stream #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .mode(mode3), .sel(sel3), .din(din3),
    .din_valid(val3), .din_ready(din_ready3), .dout(dout3),
    .dout_valid(dout_valid3), .dout_ready(rdy3), .dout_src(dout_src3)
`ifdef MUX_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt(gc3)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, index 0 = 4-channel, 1 = 3-channel.
  logic        m_v   [2];
  logic [31:0] m_d   [2];
  int          m_s   [2];
  int          m_ptr [2];
  int          m_cnt [2][4];

  logic [3:0] last_rdy4;
  logic [2:0] last_rdy3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel chosen by the rules, or -1 when nothing is granted.
  function automatic int grant(input int depth, input logic mode, input int sel,
                               input logic [3:0] v, input int ptr);
    if (!mode) begin
      if (sel < depth && v[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < depth; k++) begin
      int c;
      c = (ptr + k) % depth;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int inst, input logic mode, input int sel,
                                           input logic [3:0] v, input logic rdy);
    int g;
    g = grant(inst == 0 ? 4 : 3, mode, sel, v, m_ptr[inst]);
    if (!reset_n || !(!m_v[inst] || rdy) || g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic model_edge(input int inst, input logic mode, input int sel,
                            input logic [3:0] v, input logic rdy, input logic [127:0] data);
    int depth, g;
    logic [127:0] tmp;
    depth = (inst == 0) ? 4 : 3;
    g = grant(depth, mode, sel, v, m_ptr[inst]);
    if (cnt_clr) for (int i = 0; i < 4; i++) m_cnt[inst][i] = 0;
    if (!m_v[inst] || rdy) begin
      if (g >= 0) begin
        tmp = data >> (g * 32);
        m_d[inst] = tmp[31:0];
        m_s[inst] = g;
        m_v[inst] = 1'b1;
        if (mode) m_ptr[inst] = (g == depth - 1) ? 0 : g + 1;
        if (!cnt_clr && m_cnt[inst][g] < 65535) m_cnt[inst][g]++;
      end else begin
        m_v[inst] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_v[n] = 1'b0; m_d[n] = '0; m_s[n] = 0; m_ptr[n] = 0;
      for (int i = 0; i < 4; i++) m_cnt[n][i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("dout4", dout4, m_d[0]);
    check("dout_valid4", dout_valid4, m_v[0]);
    check("dout_src4", dout_src4, m_s[0]);
    check("dout3", dout3, m_d[1]);
    check("dout_valid3", dout_valid3, m_v[1]);
    check("dout_src3", dout_src3, m_s[1]);
`ifdef MUX_GRANT_CNT_EN
    for (int i = 0; i < 4; i++) check("grant_cnt4", gc4[i*16 +: 16], m_cnt[0][i]);
    for (int i = 0; i < 3; i++) check("grant_cnt3", gc3[i*16 +: 16], m_cnt[1][i]);
`endif
  endtask

  // One clock cycle: check combinational ready mid-cycle, advance the model
  // at the edge, then check registered outputs 1ns after the edge.
  task automatic step();
    #1;
    last_rdy4 = din_ready4;
    last_rdy3 = din_ready3;
    check("din_ready4", din_ready4, exp_ready(0, mode4, int'(sel4), val4, rdy4));
    check("din_ready3", din_ready3, exp_ready(1, mode3, int'(sel3), {1'b0, val3}, rdy3));
    @(posedge clk);
    model_edge(0, mode4, int'(sel4), val4, rdy4, din4);
    model_edge(1, mode3, int'(sel3), {1'b0, val3}, rdy3, {32'h0, din3});
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] held;
    int exp_fair [6];
    int exp_skip [4];
    exp_fair = '{0, 1, 2, 3, 0, 1};
    exp_skip = '{3, 1, 3, 1};
    model_reset();

    // Reset state, with requests already pending.
    val4 = 4'b1111; val3 = 3'b111;
    @(posedge clk); #1;
    check("rst_ready4", din_ready4, 4'b0000);
    check("rst_ready3", din_ready3, 3'b000);
    check_outputs();
    reset_n = 1'b1;

    // Explicit select of channel 2.
    mode4 = 1'b0; sel4 = 2'd2; val4 = 4'b0100; rdy4 = 1'b1;
    din4 = {32'h4444_0003, 32'hDEADBEEF, 32'h4444_0001, 32'h4444_0000};
    mode3 = 1'b0; sel3 = 2'd1; val3 = 3'b111; rdy3 = 1'b1;
    din3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    step();
    check("sel_accept_ready", last_rdy4, 4'b0100);
    check("sel_dout", dout4, 32'hDEADBEEF);
    check("sel_src", dout_src4, 2'd2);
    check("sel_valid", dout_valid4, 1'b1);

    // Backpressure: all channels requesting, consumer stalled for 5 cycles.
    rdy4 = 1'b0; val4 = 4'b1111; sel4 = 2'd1; rdy3 = 1'b0;
    din4 = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    held = dout4;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", last_rdy4, 4'b0000);
      check("bp_hold", dout4, held);
    end
    // Release: drain and reload in the same cycle. The 3-channel instance
    // switches to an out-of-range select at the same time.
    rdy4 = 1'b1; rdy3 = 1'b1; sel3 = 2'd3;
    step();
    check("bp_release_ready", last_rdy4, 4'b0010);
    check("bp_reload", dout4, 32'hA0A0_0001);
    check("oor_ready", last_rdy3, 3'b000);
    check("oor_valid", dout_valid3, 1'b0);
    check("oor_hold", dout3, 32'h3333_0001);

    // Round-robin fairness from pointer 0.
    mode4 = 1'b1; val4 = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_fair", dout_src4, exp_fair[i]);
    end
    // Pointer is now 2; channels 1 and 3 requesting.
    val4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_skip", dout_src4, exp_skip[i]);
    end

    // Randomized mix of modes, selects, requests, data and backpressure.
    for (int i = 0; i < 300; i++) begin
      mode4 = 1'($urandom_range(0, 1));
      sel4  = 2'($urandom_range(0, 3));
      val4  = 4'($urandom);
      rdy4  = ($urandom_range(0, 3) != 0);
      din4  = {$urandom, $urandom, $urandom, $urandom};
      mode3 = 1'($urandom_range(0, 1));
      sel3  = 2'($urandom_range(0, 3));
      val3  = 3'($urandom);
      rdy3  = ($urandom_range(0, 3) != 0);
      din3  = {$urandom, $urandom, $urandom};
      cnt_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    cnt_clr = 1'b0;

    // Make sure something is in flight, then reset between edges.
    mode4 = 1'b1; val4 = 4'b1111; rdy4 = 1'b1;
    mode3 = 1'b1; val3 = 3'b111; rdy3 = 1'b1;
    step();
    step();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_valid4", dout_valid4, 1'b0);
    check("async_dout4", dout4, 32'h0);
    check("async_src4", dout_src4, 2'd0);
    check("async_ready4", din_ready4, 4'b0000);
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    reset_n = 1'b1;
    step();
    check("rr_restart4", dout_src4, 2'd0);
    check("rr_restart3", dout_src3, 2'd0);
    step();
    check("rr_restart4_next", dout_src4, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
